// File: rtl/priority_resolver_isr.sv
// Priority resolver and In-Service Register for an 8-level interrupt controller.
// Picks the winning request, runs the INTA acknowledge sequence and handles EOI and rotation.
module priority_resolver_isr #(
  parameter bit         TWO_PULSE_ACK = 1'b1,
  parameter logic [2:0] RESET_LOWEST  = 3'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] risedBits,
  input  logic       inta,
  input  logic       autoEoi,
  input  logic       eoiStrobe,
  input  logic       eoiSpecific,
  input  logic       eoiRotate,
  input  logic       setPriority,
  input  logic [2:0] eoiLevel,
  output logic       intReq,
  output logic       readPriority,
  output logic [2:0] resetIRR,
  output logic       vectorValid,
  output logic [2:0] vectorIndex,
  output logic       spurious,
  output logic [7:0] isr,
  output logic [2:0] lowestPriority
);

  typedef enum logic [1:0] {IDLE, PENDING, ACK1, VECTOR} state_t;

  state_t     state_q, state_d;
  logic [2:0] latched_q, latched_d;
  logic       spur_path_q, spur_path_d;
  logic [7:0] isr_q, isr_d;
  logic [2:0] lowest_q, lowest_d;
  logic       int_req_q, int_req_d;
  logic       read_priority_q, read_priority_d;
  logic [2:0] reset_irr_q, reset_irr_d;
  logic       vector_valid_q, vector_valid_d;
  logic [2:0] vector_index_q, vector_index_d;
  logic       spurious_q, spurious_d;

  logic       req_found, isr_found, win_valid;
  logic [2:0] req_lvl, req_rank, isr_lvl, isr_rank, lvl, rank;

  // Scan ranks from lowest to highest so the last hit is the best-ranked set bit.
  always_comb begin
    req_found = 1'b0;
    req_lvl   = '0;
    req_rank  = '0;
    isr_found = 1'b0;
    isr_lvl   = '0;
    isr_rank  = '0;
    lvl       = '0;
    rank      = '0;
    for (int unsigned r = 0; r < 8; r++) begin
      rank = 3'(7 - r);
      lvl  = lowest_q + 3'd1 + rank;
      if (risedBits[lvl]) begin
        req_found = 1'b1;
        req_lvl   = lvl;
        req_rank  = rank;
      end
      if (isr_q[lvl]) begin
        isr_found = 1'b1;
        isr_lvl   = lvl;
        isr_rank  = rank;
      end
    end
    win_valid = req_found && (!isr_found || (req_rank < isr_rank));
  end

  always_comb begin
    state_d         = state_q;
    latched_d       = latched_q;
    spur_path_d     = spur_path_q;
    isr_d           = isr_q;
    lowest_d        = lowest_q;
    read_priority_d = 1'b0;
    reset_irr_d     = reset_irr_q;

    unique case (state_q)
      IDLE: begin
        if (win_valid) state_d = PENDING;
      end
      PENDING: begin
        if (inta) begin
          if (win_valid) begin
            latched_d       = req_lvl;
            spur_path_d     = 1'b0;
            read_priority_d = 1'b1;
            reset_irr_d     = req_lvl;
          end else begin
            latched_d   = 3'd7;
            spur_path_d = 1'b1;
          end
          state_d = TWO_PULSE_ACK ? ACK1 : VECTOR;
        end else if (!win_valid) begin
          state_d = IDLE;
        end
      end
      ACK1: begin
        if (inta) state_d = VECTOR;
      end
      VECTOR: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Later updates override earlier ones: EOI rotation beats setPriority, acknowledge set beats any clear.
    if (setPriority) lowest_d = eoiLevel;
    if (eoiStrobe) begin
      if (eoiSpecific) begin
        isr_d[eoiLevel] = 1'b0;
        if (eoiRotate) lowest_d = eoiLevel;
      end else if (isr_found) begin
        isr_d[isr_lvl] = 1'b0;
        if (eoiRotate) lowest_d = isr_lvl;
      end
    end
    if (state_q == VECTOR && autoEoi && !spur_path_q) begin
      isr_d[latched_q] = 1'b0;
      if (eoiRotate) lowest_d = latched_q;
    end
    if (read_priority_d) isr_d[req_lvl] = 1'b1;

    int_req_d      = (state_d == PENDING);
    vector_valid_d = (state_d == VECTOR);
    vector_index_d = (state_d == VECTOR) ? latched_d : vector_index_q;
    spurious_d     = (state_d == VECTOR) && spur_path_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      latched_q       <= '0;
      spur_path_q     <= 1'b0;
      isr_q           <= '0;
      lowest_q        <= RESET_LOWEST;
      int_req_q       <= 1'b0;
      read_priority_q <= 1'b0;
      reset_irr_q     <= '0;
      vector_valid_q  <= 1'b0;
      vector_index_q  <= '0;
      spurious_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      latched_q       <= latched_d;
      spur_path_q     <= spur_path_d;
      isr_q           <= isr_d;
      lowest_q        <= lowest_d;
      int_req_q       <= int_req_d;
      read_priority_q <= read_priority_d;
      reset_irr_q     <= reset_irr_d;
      vector_valid_q  <= vector_valid_d;
      vector_index_q  <= vector_index_d;
      spurious_q      <= spurious_d;
    end
  end

  assign intReq         = int_req_q;
  assign readPriority   = read_priority_q;
  assign resetIRR       = reset_irr_q;
  assign vectorValid    = vector_valid_q;
  assign vectorIndex    = vector_index_q;
  assign spurious       = spurious_q;
  assign isr            = isr_q;
  assign lowestPriority = lowest_q;

endmodule
